// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NUM_REQ requesters.
// Optional ALU_ARB_LOCK_EN adds req_lock so one owner can hold the ALU across a multi-word chain.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic [2:0]               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_zero
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

`ifdef ALU_ARB_LOCK_EN
  logic locked;
`endif

  // NOTE: every variable gets a default before the scan so no path leaves it unassigned (no latch).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`ifdef ALU_ARB_LOCK_EN
    // A locked owner is the only candidate; everyone else waits.
    if (locked) begin
      grant_found = req_valid[owner];
      grant_idx   = owner;
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state != EXEC && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (!rst && state == DONE) rsp_valid[owner] = 1'b1;
  end

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      // NOTE: payload regs are reset because they drive alu_* directly and must read 0 after reset.
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      locked     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (grant_found) begin
            op_q  <= req_op[3*grant_idx +: 3];
            a_q   <= req_a[WIDTH*grant_idx +: WIDTH];
            b_q   <= req_b[WIDTH*grant_idx +: WIDTH];
            owner <= grant_idx;
            state <= EXEC;
`ifdef ALU_ARB_LOCK_EN
            if (!locked) last_grant <= grant_idx;
            locked <= req_lock[grant_idx];
`else
            last_grant <= grant_idx;
`endif
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_carry <= alu_carry;
          rsp_zero  <= alu_zero;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed scenarios, then randomized traffic with resets.
// Define ALU_ARB_LOCK_EN for both files to exercise the lock scenario.
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
`ifdef ALU_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock = '0;
`endif
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_out;
  logic                     rsp_carry;
  logic                     rsp_zero;
  logic [2:0]               alu_op;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [WIDTH-1:0]         alu_out;
  logic                     alu_carry;
  logic                     alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  // Returns {carry, zero, result}; SUB carry is the borrow.
  function automatic logic [17:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    s = '0;
    c = 1'b0;
    case (op)
      3'd0:    begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      3'd1:    begin r = a - b; c = (a < b); end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = ~a;
      3'd5:    r = a ^ b;
      3'd6:    begin r = {a[14:0], a[15]}; c = a[15]; end
      default: begin r = {a[0], a[15:1]}; c = a[0]; end
    endcase
    return {c, (r == 16'h0), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_out} = alu_ref(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycles since the last accepted transfer decide ready and response timing.
  int                 since = 99;
  int                 last_m = NUM_REQ - 1;
  int                 owner_m = 0;
  int                 g_m;
  int                 cyc = 0;
  bit                 locked_m = 1'b0;
  logic [17:0]        pend = '0;
  logic [17:0]        held = '0;
  logic [NUM_REQ-1:0] exp_rv;
  logic [NUM_REQ-1:0] exp_rdy;
  bit   [NUM_REQ-1:0] accepted = '0;
  int                 grant_log[$];
  logic [19:0]        rsp_log[$];
  int                 rsp_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      since = 99; last_m = NUM_REQ - 1; held = '0; locked_m = 1'b0; accepted = '0;
    end else begin
      exp_rv = '0;
      if (since == 2) begin
        exp_rv[owner_m] = 1'b1;
        held = pend;
      end
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_data", {rsp_carry, rsp_zero, rsp_out}, held);
      if (rsp_valid != '0) begin
        rsp_log.push_back({rsp_valid, rsp_carry, rsp_zero, rsp_out});
        rsp_cyc.push_back(cyc);
      end
      g_m = -1;
      if (since != 1) begin
        if (locked_m) begin
          if (req_valid[owner_m]) g_m = owner_m;
        end else begin
          for (int k = 1; k <= NUM_REQ; k++)
            if (g_m < 0 && req_valid[(last_m + k) % NUM_REQ]) g_m = (last_m + k) % NUM_REQ;
        end
      end
      exp_rdy = '0;
      if (g_m >= 0) exp_rdy[g_m] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (g_m >= 0) begin
        owner_m = g_m;
        pend = alu_ref(req_op[3*g_m +: 3], req_a[16*g_m +: 16], req_b[16*g_m +: 16]);
        if (!locked_m) last_m = g_m;
`ifdef ALU_ARB_LOCK_EN
        locked_m = req_lock[g_m];
`endif
        accepted[g_m] = 1'b1;
        grant_log.push_back(g_m);
        since = 1;
      end else if (since < 99) begin
        since++;
      end
    end
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]       = 1'b1;
    req_op[3*i +: 3]   = op;
    req_a[16*i +: 16]  = a;
    req_b[16*i +: 16]  = b;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
  endtask

  function automatic int grant_at(input int idx);
    return (grant_log.size() > idx) ? grant_log[idx] : -1;
  endfunction

  function automatic logic [19:0] rsp_at(input int idx);
    return (rsp_log.size() > idx) ? rsp_log[idx] : 20'hFFFFF;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_alu_outputs", {alu_op, alu_a, alu_b}, 0);

    // ADD 0xFFFF + 1 from req0 right after reset
    clear_logs();
    set_req(0, 3'd0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    check("add_ready0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    wait_cycles(3);
    check("add_rsp_cnt", rsp_log.size(), 1);
    check("add_rsp", rsp_at(0), {2'b01, 1'b1, 1'b1, 16'h0000});

    // Both requesters continuously valid: strict alternation
    do_reset();
    clear_logs();
    set_req(0, 3'd1, 16'h0003, 16'h0005);
    set_req(1, 3'd2, 16'hF0F0, 16'h0FF0);
    wait_cycles(7);
    req_valid = '0;
    wait_cycles(4);
    check("rr_grant_cnt", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check("rr_grant_order", grant_at(i), i % 2);
    check("rr_rsp_sub", rsp_at(0), {2'b01, 1'b1, 1'b0, 16'hFFFE});
    check("rr_rsp_and", rsp_at(1), {2'b10, 1'b0, 1'b0, 16'h00F0});

    // Single active requester gets every slot
    clear_logs();
    set_req(1, 3'd6, 16'h8001, 16'h0000);
    wait_cycles(5);
    req_valid = '0;
    wait_cycles(4);
    check("solo_grant_cnt", grant_log.size(), 3);
    check("solo_rsp_cnt", rsp_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("solo_grant", grant_at(i), 1);
      check("solo_rsp", rsp_at(i), {2'b10, 1'b1, 1'b0, 16'h0003});
    end
    check("solo_spacing_a", (rsp_cyc.size() > 1) ? rsp_cyc[1] - rsp_cyc[0] : -1, 2);
    check("solo_spacing_b", (rsp_cyc.size() > 2) ? rsp_cyc[2] - rsp_cyc[1] : -1, 2);

    // Reset during EXEC discards the op and resets the pointer
    clear_logs();
    set_req(0, 3'd5, 16'h1234, 16'h1234);
    wait_cycles(1);
    req_valid = '0;
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(3);
    check("rstexec_no_rsp", rsp_log.size(), 0);
    check("rstexec_rsp_regs", {rsp_carry, rsp_zero, rsp_out}, 0);
    check("rstexec_alu_regs", {alu_op, alu_a, alu_b}, 0);
    set_req(0, 3'd0, 16'h0001, 16'h0001);
    set_req(1, 3'd3, 16'h0101, 16'h1010);
    @(negedge clk);
    check("rstexec_next_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    wait_cycles(4);

    // Requester withdraws before it is ever granted
    clear_logs();
    set_req(0, 3'd0, 16'h0010, 16'h0020);
    wait_cycles(1);
    req_valid[0] = 1'b0;
    set_req(1, 3'd4, 16'h00FF, 16'h0000);
    wait_cycles(1);
    req_valid[1] = 1'b0;
    wait_cycles(4);
    check("drop_grant_cnt", grant_log.size(), 1);
    check("drop_grant", grant_at(0), 0);
    check("drop_rsp", rsp_at(0), {2'b01, 1'b0, 1'b0, 16'h0030});

`ifdef ALU_ARB_LOCK_EN
    // req0 holds the lock for a three-word chain while req1 waits
    do_reset();
    clear_logs();
    accepted = '0;
    set_req(1, 3'd0, 16'h0001, 16'h0002);
    set_req(0, 3'd0, 16'hFFFF, 16'h0001);
    req_lock[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int t = 0; t < 20 && !accepted[0]; t++) wait_cycles(1);
      accepted[0] = 1'b0;
      if (n == 1) req_lock[0] = 1'b0;
      if (n == 2) req_valid[0] = 1'b0;
    end
    wait_cycles(6);
    req_valid = '0;
    wait_cycles(4);
    check("lock_g0", grant_at(0), 0);
    check("lock_g1", grant_at(1), 0);
    check("lock_g2", grant_at(2), 0);
    check("lock_g3", grant_at(3), 1);
`endif

    // Randomized traffic with occasional withdrawals and resets
    accepted = '0;
    for (int c = 0; c < 3000; c++) begin
      wait_cycles(1);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || accepted[i]) begin
          accepted[i] = 1'b0;
          if ($urandom_range(0, 2) != 0) begin
            set_req(i, 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
`ifdef ALU_ARB_LOCK_EN
            req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    wait_cycles(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
